color_histogram: RTL and testbench
==================================

Name: color_histogram

Overview:
- Upstream stage of the centroid/proximity block.
- Consumes the colour-filtered QQVGA pixel stream and accumulates, over the inner frame only, the total passing-pixel count and an 8-bin column histogram.
- At end of frame it snapshots the counts plus the derived partial sums (left/right, outer-2, outer-3) and pulses new_frame_proc_o, which drives the centroid stage directly.

Parameters:
- c_img_cols, 160, image columns
- c_img_rows, 120, image rows
- c_nb_cols, $clog2(c_img_cols) = 8, column index width
- c_nb_rows, $clog2(c_img_rows) = 7, row index width
- c_inframe_cols, 128, inner-frame columns; centred, so cols 16..143
- c_inframe_rows, 104, inner-frame rows; centred, so rows 8..111
- c_nb_inframe_pxls, $clog2(128*104) = 14, total-count width
- c_hist_bins, 8, histogram bins; 16 columns each
- c_nb_hist_val, $clog2(104*16) = 11, per-bin count width

Ports:
- clk  in  1  FPGA clock
- rst  in  1  reset: synchronous, active-high
- pxl_valid_i  in  1  pixel qualifier, one pixel per asserted cycle
- col_i  in  c_nb_cols  pixel column, 0..159
- row_i  in  c_nb_rows  pixel row, 0..119
- colorpxl_i  in  1  pixel passed the colour filter
- colorpxls_o  out  14  inner-frame passing total
- colorpxls_bin0_o .. colorpxls_bin7_o  out  11 each  per-bin counts
- colorpxls_left_o, colorpxls_rght_o  out  13  bins 0-3 / bins 4-7
- colorpxls_bin012_o, colorpxls_bin567_o  out  13  outer-3 sums
- colorpxls_bin01_o, colorpxls_bin67_o  out  13  outer-2 sums
- new_frame_proc_o  out  1  one-cycle pulse: snapshot outputs updated
- frame_err_o  out  1  present only with the optional feature

Behaviour:
- Reset, synchronous on rst=1:
  - all accumulators, all outputs and new_frame_proc_o go to 0
  - FSM goes to IDLE
  - applies identically mid-frame; a partial frame is discarded with no pulse
- Inner-frame test: 16<=col_i<=143 and 8<=row_i<=111.
- Bin index: (col_i-16)>>4, using 3 bits of the 8-bit difference.
- FSM states and transitions:
  - IDLE: wait for pxl_valid_i with col=0,row=0 (frame start). On start, clear the accumulators, count this pixel (it is never inner), go to ACCUM.
  - ACCUM: on each valid inner pixel with colorpxl_i=1, increment the total and the selected bin by 1.
  - ACCUM, last pixel (valid, col=159, row=119): the snapshot registers load next-state accumulator values, so the last pixel is included. Go to DONE.
  - ACCUM, frame start seen before the last pixel (truncated frame): discard, re-clear, count the start pixel, stay in ACCUM, no pulse.
  - DONE: new_frame_proc_o=1 for exactly this cycle; snapshot outputs are already stable. A frame-start pixel arriving in DONE is handled as in IDLE (go to ACCUM). Otherwise go to IDLE.
- Latency: outputs valid and pulse asserted 1 cycle after the clock edge that samples the last pixel.
- Snapshot outputs hold until the next completed frame.
- Partial sums: registered at snapshot time from the snapshotted bins; zero-extended adds, no overflow possible.
- Counters never saturate; maxima are 1664 per bin and 13312 total, both within width.
- pxl_valid_i=0 cycles are ignored in every state. col_i, row_i and colorpxl_i are don't-care when pxl_valid_i=0.

Optional Feature:
- Macro: COLOR_HIST_FRAME_CHECK_EN.
- Defined:
  - a 15-bit counter counts valid pixels per frame
  - frame_err_o is set for the DONE cycle if the count != 19200
  - frame_err_o is also pulsed for 1 cycle on a truncated-frame restart
  - frame_err_o resets to 0
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package color_hist_pkg:
  - image/inner-frame dimension constants and bounds (16, 143, 8, 111)
  - width constants
  - FSM state typedef {IDLE, ACCUM, DONE}
- Sub-module hist_bin_counter, instantiated 8 times:
  - synchronous clear, enable increment, load-to-snapshot, c_nb_hist_val wide
- The total counter and partial-sum adders stay in the top.

Test Plan:
- Full frame, all pixels colorpxl_i=1 -> colorpxls_o=13312, each bin=1664, left=rght=6656, bin01=3328, bin012=4992; one pulse 1 cycle after pixel (159,119).
- Only column 16 passes, rows 8..111 -> bin0=104, total=104, all other bins 0, bin01=bin012=left=104.
- Border pixels only (col 0..15, 144..159, rows 0..7, 112..119) passing -> all outputs 0, pulse still issued.
- Frame restart at (0,0) after 5000 pixels, then a full frame with only bin7 passing -> single pulse, bin7=1664, bin0..bin6=0, total=1664; no contribution from the aborted frame. With macro defined: frame_err_o pulses once at the restart and is 0 at DONE.
- rst asserted mid-frame for 1 cycle -> next clock all outputs 0, FSM in IDLE, no pulse until a new full frame completes.
- Valid pixels interleaved with random pxl_valid_i=0 gaps -> results identical to the gapless run. With macro defined: a frame missing 1 pixel gives frame_err_o=1 in the DONE cycle.

Source files
------------

// File: rtl/color_hist_pkg.sv
// Shared dimensions, inner-frame bounds, widths and FSM state type for color_histogram.
package color_hist_pkg;

    localparam int c_img_cols        = 160;
    localparam int c_img_rows        = 120;
    localparam int c_nb_cols         = $clog2(c_img_cols);
    localparam int c_nb_rows         = $clog2(c_img_rows);
    localparam int c_inframe_cols    = 128;
    localparam int c_inframe_rows    = 104;
    localparam int c_nb_inframe_pxls = $clog2(c_inframe_cols * c_inframe_rows);
    localparam int c_hist_bins       = 8;
    localparam int c_bin_cols        = c_inframe_cols / c_hist_bins;
    localparam int c_nb_hist_val     = $clog2(c_inframe_rows * c_bin_cols);
    localparam int c_nb_part_sum     = 13;

    localparam int c_col_first = (c_img_cols - c_inframe_cols) / 2;
    localparam int c_col_last  = c_col_first + c_inframe_cols - 1;
    localparam int c_row_first = (c_img_rows - c_inframe_rows) / 2;
    localparam int c_row_last  = c_row_first + c_inframe_rows - 1;

    localparam int c_frame_pxls   = c_img_cols * c_img_rows;
    localparam int c_nb_frame_cnt = 15;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } hist_state_t;

    function automatic logic in_inner_frame(input logic [c_nb_cols-1:0] col,
                                            input logic [c_nb_rows-1:0] row);
        return (col >= c_nb_cols'(c_col_first)) && (col <= c_nb_cols'(c_col_last)) &&
               (row >= c_nb_rows'(c_row_first)) && (row <= c_nb_rows'(c_row_last));
    endfunction

    // Only meaningful for inner-frame columns; the difference wraps otherwise.
    function automatic logic [2:0] bin_index(input logic [c_nb_cols-1:0] col);
        logic [c_nb_cols-1:0] offs;
        offs = col - c_nb_cols'(c_col_first);
        return 3'(offs >> 4);
    endfunction

endpackage

// File: rtl/hist_bin_counter.sv
// One histogram bin: running count with clear/increment and a snapshot register
// that captures the count including the current cycle's increment.
module hist_bin_counter
    import color_hist_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     inc,
    input  logic                     load,
    output logic [c_nb_hist_val-1:0] cnt_next,
    output logic [c_nb_hist_val-1:0] snap
);

    logic [c_nb_hist_val-1:0] cnt;

    always_comb begin
        cnt_next = cnt;
        if (clr) begin
            cnt_next = '0;
        end else if (inc) begin
            cnt_next = cnt + c_nb_hist_val'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            snap <= '0;
        end else begin
            cnt <= cnt_next;
            if (load) begin
                snap <= cnt_next;
            end
        end
    end

endmodule

// File: rtl/color_histogram.sv
// Inner-frame colour-pixel total and 8-bin column histogram with end-of-frame snapshot.
// Optional per-frame pixel-count check: define COLOR_HIST_FRAME_CHECK_EN to add frame_err_o.
module color_histogram
    import color_hist_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pxl_valid_i,
    input  logic [c_nb_cols-1:0]         col_i,
    input  logic [c_nb_rows-1:0]         row_i,
    input  logic                         colorpxl_i,
    output logic [c_nb_inframe_pxls-1:0] colorpxls_o,
    output logic [c_nb_hist_val-1:0]     colorpxls_bin0_o,
    output logic [c_nb_hist_val-1:0]     colorpxls_bin1_o,
    output logic [c_nb_hist_val-1:0]     colorpxls_bin2_o,
    output logic [c_nb_hist_val-1:0]     colorpxls_bin3_o,
    output logic [c_nb_hist_val-1:0]     colorpxls_bin4_o,
    output logic [c_nb_hist_val-1:0]     colorpxls_bin5_o,
    output logic [c_nb_hist_val-1:0]     colorpxls_bin6_o,
    output logic [c_nb_hist_val-1:0]     colorpxls_bin7_o,
    output logic [c_nb_part_sum-1:0]     colorpxls_left_o,
    output logic [c_nb_part_sum-1:0]     colorpxls_rght_o,
    output logic [c_nb_part_sum-1:0]     colorpxls_bin012_o,
    output logic [c_nb_part_sum-1:0]     colorpxls_bin567_o,
    output logic [c_nb_part_sum-1:0]     colorpxls_bin01_o,
    output logic [c_nb_part_sum-1:0]     colorpxls_bin67_o,
`ifdef COLOR_HIST_FRAME_CHECK_EN
    output logic                         frame_err_o,
`endif
    output logic                         new_frame_proc_o
);

    hist_state_t state, state_nxt;

    logic frame_start;
    logic last_pxl;
    logic inner_hit;
    logic acc_clr;
    logic acc_en;
    logic snap_load;
    logic [2:0] bin_sel;

    logic [c_nb_hist_val-1:0]     bin_next [c_hist_bins];
    logic [c_nb_hist_val-1:0]     bin_snap [c_hist_bins];
    logic [c_nb_inframe_pxls-1:0] total;
    logic [c_nb_inframe_pxls-1:0] total_next;

    function automatic logic [c_nb_part_sum-1:0] widen(input logic [c_nb_hist_val-1:0] v);
        return c_nb_part_sum'(v);
    endfunction

    assign frame_start = pxl_valid_i && (col_i == '0) && (row_i == '0);
    assign last_pxl    = pxl_valid_i && (col_i == c_nb_cols'(c_img_cols - 1)) &&
                         (row_i == c_nb_rows'(c_img_rows - 1));
    assign inner_hit   = pxl_valid_i && colorpxl_i && in_inner_frame(col_i, row_i);
    assign bin_sel     = bin_index(col_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A frame start always re-clears, whether it opens a frame or truncates one.
    always_comb begin
        state_nxt = state;
        acc_clr   = 1'b0;
        acc_en    = 1'b0;
        snap_load = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) begin
                    acc_clr   = 1'b1;
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                if (frame_start) begin
                    acc_clr = 1'b1;
                end else begin
                    acc_en = inner_hit;
                    if (last_pxl) begin
                        snap_load = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                if (frame_start) begin
                    acc_clr   = 1'b1;
                    state_nxt = ACCUM;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign new_frame_proc_o = (state == DONE);

    for (genvar b = 0; b < c_hist_bins; b++) begin : g_bin
        hist_bin_counter u_bin (
            .clk      (clk),
            .rst      (rst),
            .clr      (acc_clr),
            .inc      (acc_en && (bin_sel == 3'(b))),
            .load     (snap_load),
            .cnt_next (bin_next[b]),
            .snap     (bin_snap[b])
        );
    end

    assign colorpxls_bin0_o = bin_snap[0];
    assign colorpxls_bin1_o = bin_snap[1];
    assign colorpxls_bin2_o = bin_snap[2];
    assign colorpxls_bin3_o = bin_snap[3];
    assign colorpxls_bin4_o = bin_snap[4];
    assign colorpxls_bin5_o = bin_snap[5];
    assign colorpxls_bin6_o = bin_snap[6];
    assign colorpxls_bin7_o = bin_snap[7];

    always_comb begin
        total_next = total;
        if (acc_clr) begin
            total_next = '0;
        end else if (acc_en) begin
            total_next = total + c_nb_inframe_pxls'(1);
        end
    end

    // Partial sums are built from the same next-state bin values the snapshot loads,
    // so they are valid together with the pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            total              <= '0;
            colorpxls_o        <= '0;
            colorpxls_left_o   <= '0;
            colorpxls_rght_o   <= '0;
            colorpxls_bin012_o <= '0;
            colorpxls_bin567_o <= '0;
            colorpxls_bin01_o  <= '0;
            colorpxls_bin67_o  <= '0;
        end else begin
            total <= total_next;
            if (snap_load) begin
                colorpxls_o        <= total_next;
                colorpxls_left_o   <= widen(bin_next[0]) + widen(bin_next[1]) +
                                      widen(bin_next[2]) + widen(bin_next[3]);
                colorpxls_rght_o   <= widen(bin_next[4]) + widen(bin_next[5]) +
                                      widen(bin_next[6]) + widen(bin_next[7]);
                colorpxls_bin012_o <= widen(bin_next[0]) + widen(bin_next[1]) + widen(bin_next[2]);
                colorpxls_bin567_o <= widen(bin_next[5]) + widen(bin_next[6]) + widen(bin_next[7]);
                colorpxls_bin01_o  <= widen(bin_next[0]) + widen(bin_next[1]);
                colorpxls_bin67_o  <= widen(bin_next[6]) + widen(bin_next[7]);
            end
        end
    end

`ifdef COLOR_HIST_FRAME_CHECK_EN
    logic [c_nb_frame_cnt-1:0] frame_cnt;
    logic [c_nb_frame_cnt-1:0] frame_cnt_next;
    logic                      restart;

    assign restart = (state == ACCUM) && frame_start;

    // The start pixel counts as the first pixel of the frame.
    always_comb begin
        frame_cnt_next = frame_cnt;
        if (acc_clr) begin
            frame_cnt_next = c_nb_frame_cnt'(1);
        end else if ((state == ACCUM) && pxl_valid_i) begin
            frame_cnt_next = frame_cnt + c_nb_frame_cnt'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt   <= '0;
            frame_err_o <= 1'b0;
        end else begin
            frame_cnt <= frame_cnt_next;
            if (snap_load) begin
                frame_err_o <= (frame_cnt_next != c_nb_frame_cnt'(c_frame_pxls));
            end else begin
                frame_err_o <= restart;
            end
        end
    end
`else
    // Without the frame check no per-frame pixel count is kept.
`endif

endmodule

// File: tb/tb_color_histogram.sv
// Randomised bench for color_histogram against a frame-level reference model.
module tb_color_histogram;

    logic        clk = 1'b0;
    logic        rst;
    logic        pxl_valid;
    logic [7:0]  col;
    logic [6:0]  row;
    logic        colorpxl;
    logic [13:0] total_o;
    logic [10:0] dut_bin [8];
    logic [12:0] left_o, rght_o, b012_o, b567_o, b01_o, b67_o;
    logic        pulse;
    logic        frame_err;

    color_histogram dut (
        .clk                (clk),
        .rst                (rst),
        .pxl_valid_i        (pxl_valid),
        .col_i              (col),
        .row_i              (row),
        .colorpxl_i         (colorpxl),
        .colorpxls_o        (total_o),
        .colorpxls_bin0_o   (dut_bin[0]),
        .colorpxls_bin1_o   (dut_bin[1]),
        .colorpxls_bin2_o   (dut_bin[2]),
        .colorpxls_bin3_o   (dut_bin[3]),
        .colorpxls_bin4_o   (dut_bin[4]),
        .colorpxls_bin5_o   (dut_bin[5]),
        .colorpxls_bin6_o   (dut_bin[6]),
        .colorpxls_bin7_o   (dut_bin[7]),
        .colorpxls_left_o   (left_o),
        .colorpxls_rght_o   (rght_o),
        .colorpxls_bin012_o (b012_o),
        .colorpxls_bin567_o (b567_o),
        .colorpxls_bin01_o  (b01_o),
        .colorpxls_bin67_o  (b67_o),
`ifdef COLOR_HIST_FRAME_CHECK_EN
        .frame_err_o        (frame_err),
`endif
        .new_frame_proc_o   (pulse)
    );

`ifndef COLOR_HIST_FRAME_CHECK_EN
    assign frame_err = 1'b0;
`endif

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: per-frame counts derived directly from the pixel rules.
    int m_bin [8];
    int m_total, m_cnt, m_restarts;
    bit m_active;
    int e_bin [8];
    int e_total, e_err;
    int spurious, err_pulses;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit inner(input int c, input int r);
        return (c >= 16) && (c <= 143) && (r >= 8) && (r <= 111);
    endfunction

    function automatic bit visit(input int mode, input int c, input int r, input int salt);
        case (mode)
            0: return inner(c, r);
            1: return (c == 16) && (r >= 8) && (r <= 111);
            2: return !inner(c, r);
            3: return (c >= 128) && (c <= 143);
            default: return (((c * 3 + r * 5 + salt) % 7) == 0) ||
                            c == 15 || c == 16 || c == 143 || c == 144 ||
                            r == 7 || r == 8 || r == 111 || r == 112;
        endcase
    endfunction

    function automatic bit pass(input int mode, input int c, input int r, input int salt);
        case (mode)
            0: return 1'b1;
            1: return c == 16;
            2: return !inner(c, r);
            3: return (c >= 128) && (c <= 143);
            default: return ((c * 11 + r * 7 + salt) % 3) != 0;
        endcase
    endfunction

    function automatic void model_reset();
        m_active = 1'b0;
        e_total  = 0;
        e_err    = 0;
        for (int b = 0; b < 8; b++) e_bin[b] = 0;
    endfunction

    function automatic void model_pixel(input int c, input int r, input bit p);
        if (c == 0 && r == 0) begin
            if (m_active) m_restarts++;
            m_active = 1'b1;
            m_total  = 0;
            m_cnt    = 0;
            for (int b = 0; b < 8; b++) m_bin[b] = 0;
        end
        if (m_active) begin
            m_cnt++;
            if (p && inner(c, r)) begin
                m_bin[(c - 16) / 16]++;
                m_total++;
            end
            if (c == 159 && r == 119) begin
                e_bin    = m_bin;
                e_total  = m_total;
                e_err    = (m_cnt != 19200);
                m_active = 1'b0;
            end
        end
    endfunction

    task automatic sample();
        if (pulse) spurious++;
        if (frame_err) err_pulses++;
    endtask

    task automatic clear_stats();
        spurious   = 0;
        err_pulses = 0;
        m_restarts = 0;
    endtask

    task automatic send(input int c, input int r, input bit p, input int gap_pct);
        while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
            @(negedge clk);
            sample();
            pxl_valid = 1'b0;
            col       = 8'($urandom_range(255));
            row       = 7'($urandom_range(127));
            colorpxl  = 1'($urandom_range(1));
        end
        @(negedge clk);
        sample();
        pxl_valid = 1'b1;
        col       = 8'(c);
        row       = 7'(r);
        colorpxl  = p;
        model_pixel(c, r, p);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".total"}, int'(total_o), e_total);
        for (int b = 0; b < 8; b++)
            check($sformatf("%s.bin%0d", tag, b), int'(dut_bin[b]), e_bin[b]);
        check({tag, ".left"},   int'(left_o), e_bin[0] + e_bin[1] + e_bin[2] + e_bin[3]);
        check({tag, ".rght"},   int'(rght_o), e_bin[4] + e_bin[5] + e_bin[6] + e_bin[7]);
        check({tag, ".bin012"}, int'(b012_o), e_bin[0] + e_bin[1] + e_bin[2]);
        check({tag, ".bin567"}, int'(b567_o), e_bin[5] + e_bin[6] + e_bin[7]);
        check({tag, ".bin01"},  int'(b01_o),  e_bin[0] + e_bin[1]);
        check({tag, ".bin67"},  int'(b67_o),  e_bin[6] + e_bin[7]);
    endtask

    // The pulse and the snapshot must appear one clock after the last pixel.
    task automatic finish_frame(input string tag);
        @(negedge clk);
        check({tag, ".pulse"}, int'(pulse), 1);
        check_outputs(tag);
`ifdef COLOR_HIST_FRAME_CHECK_EN
        check({tag, ".err_done"}, int'(frame_err), e_err);
        check({tag, ".err_pulses"}, err_pulses, m_restarts);
`endif
        check({tag, ".spurious"}, spurious, 0);
        pxl_valid = 1'b0;
        @(negedge clk);
        check({tag, ".pulse_end"}, int'(pulse), 0);
    endtask

    task automatic frame(input string tag, input int mode, input bit full, input int gap_pct,
                         input int stop_after, input bit drop_one, input int salt);
        int sent;
        sent = 0;
        for (int r = 0; r < 120; r++) begin
            for (int c = 0; c < 160; c++) begin
                bit edge_px;
                if (stop_after > 0 && sent >= stop_after) return;
                edge_px = (c == 0 && r == 0) || (c == 159 && r == 119);
                if (drop_one && c == 80 && r == 60) continue;
                if (!(full || edge_px || visit(mode, c, r, salt))) continue;
                send(c, r, pass(mode, c, r, salt), gap_pct);
                sent++;
            end
        end
        finish_frame(tag);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int salt;
        rst       = 1'b1;
        pxl_valid = 1'b0;
        col       = '0;
        row       = '0;
        colorpxl  = 1'b0;
        model_reset();
        clear_stats();
        repeat (3) @(negedge clk);
        check_outputs("reset");
        check("reset.pulse", int'(pulse), 0);
        check("reset.err", int'(frame_err), 0);
        rst = 1'b0;

        clear_stats();
        frame("all_pass", 0, 1'b1, 0, 0, 1'b0, 0);

        clear_stats();
        frame("col16", 1, 1'b0, 0, 0, 1'b0, 0);

        clear_stats();
        frame("border", 2, 1'b0, 0, 0, 1'b0, 0);

        // Aborted frame of all-passing pixels, then a restarted frame with only bin7 passing.
        clear_stats();
        frame("aborted", 0, 1'b1, 0, 5000, 1'b0, 0);
`ifdef COLOR_HIST_FRAME_CHECK_EN
        frame("restart_bin7", 3, 1'b1, 0, 0, 1'b0, 0);
`else
        frame("restart_bin7", 3, 1'b0, 0, 0, 1'b0, 0);
`endif

        // Mid-frame reset: partial frame is discarded and nothing completes without a new start.
        clear_stats();
        frame("pre_rst", 0, 1'b1, 0, 300, 1'b0, 0);
        @(negedge clk);
        rst       = 1'b1;
        pxl_valid = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        check_outputs("mid_rst");
        check("mid_rst.pulse", int'(pulse), 0);
        check("mid_rst.err", int'(frame_err), 0);
        clear_stats();
        for (int c = 0; c < 160; c++) send(c, 60, 1'b1, 0);
        send(159, 119, 1'b1, 0);
        @(negedge clk);
        sample();
        pxl_valid = 1'b0;
        @(negedge clk);
        sample();
        check("post_rst.no_pulse", spurious, 0);
        check_outputs("post_rst");

        salt = int'($urandom_range(1000));
        clear_stats();
        frame("rand_nogap", 4, 1'b0, 0, 0, 1'b0, salt);
        clear_stats();
        frame("rand_gap", 4, 1'b0, 30, 0, 1'b0, salt);
        salt = int'($urandom_range(1000));
        clear_stats();
        frame("rand_gap2", 4, 1'b0, 20, 0, 1'b0, salt);

`ifdef COLOR_HIST_FRAME_CHECK_EN
        clear_stats();
        frame("missing_one", 0, 1'b1, 10, 0, 1'b1, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
